// File: rtl/pipe_pkg.sv
// Shared types for the pipe_reg pipeline stage: occupancy state and count.
package pipe_pkg;

  // Occupancy of the stage; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Number of entries held (0..2).
  typedef logic [1:0] count_t;

  // Entry count presented on the count port for a given occupancy state.
  function automatic count_t state_count(input state_t s);
    return count_t'(s);
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// Single payload register with load enable; resets to RESET_VAL.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Payload storage: capture d when load is asserted.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the entry is reset because its value is architecturally visible on out_data after reset.
    if (!rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      // NOTE: non-blocking so every flop samples pre-edge values, independent of block order.
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Valid/ready pipeline register stage.
// Build option PIPE_REG_SKID_EN: adds a skid entry (state TWO) so in_ready is
// registered and has no combinational dependence on out_ready. Without it the
// stage holds one entry and in_ready = (count == 0) || out_ready.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output count_t           count
);

  state_t           state_q;
  state_t           state_d;
  logic             push;
  logic             pop;
  logic             main_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;

  assign push = in_valid && in_ready;
  assign pop  = (state_q != EMPTY) && out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_REG_SKID_EN

  logic             skid_load;
  logic [WIDTH-1:0] skid_d;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;

  // Next-state and entry load decode; flush overrides every handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    main_load = 1'b0;
    main_d    = in_data;
    skid_load = 1'b0;
    skid_d    = in_data;
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b1;
      main_d    = RESET_VAL;
      skid_load = 1'b1;
      skid_d    = RESET_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can happen; skid moves to main.
          if (pop) begin
            state_d   = ONE;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Registered in_ready: high whenever the next state still has room.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_d != TWO);
    end
  end

  assign in_ready = in_ready_q;

  pipe_entry #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (skid_d),
    .q    (skid_q)
  );

`else

  // Next-state and main load decode for the single-entry build.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_d    = in_data;
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b1;
      main_d    = RESET_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          // A push in ONE implies out_ready, hence a same-cycle pop: main reloads.
          if (push) begin
            main_load = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign in_ready = (state_q == EMPTY) || out_ready;

`endif

  pipe_entry #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_count(state_q);

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg; follows the PIPE_REG_SKID_EN build option.
module tb_pipe_reg;

  localparam int             W  = 16;
  localparam logic [W-1:0]   RV = 16'hA5C3;
`ifdef PIPE_REG_SKID_EN
  localparam int             MAX_CNT = 2;
`else
  localparam int             MAX_CNT = 1;
`endif

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic         flush     = 1'b0;
  logic         in_valid  = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int passed = 0;
  int total  = 0;

  // Reference model: the entries currently held, oldest first.
  logic [W-1:0] exp_q[$];

  pipe_reg #(
    .WIDTH     (W),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Whether the stage accepts input this cycle, from model occupancy.
  function automatic bit model_ready();
`ifdef PIPE_REG_SKID_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || out_ready;
`endif
  endfunction

  // Advance one clock and apply the same transfers to the model.
  task automatic tick();
    bit do_push;
    bit do_pop;
    do_push = in_valid && model_ready() && !flush;
    do_pop  = (exp_q.size() > 0) && out_ready && !flush;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(in_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (count !== 2'd0)    $display("FAIL reset_count got %0d want 0", count); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== RV)   $display("FAIL reset_out_data got %h want %h", out_data, RV); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready); else passed++;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); else passed++;
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== W'(i))
        $display("FAIL stream_data[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, W'(i));
      else passed++;
      total++; if (count !== 2'd1) $display("FAIL stream_count[%0d] got %0d want 1", i, count); else passed++;
    end
    in_valid = 1'b0;
    tick();
    total++; if (count !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL stream_drain got count=%0d v=%b want 0/0", count, out_valid);
    else passed++;
  endtask

`ifdef PIPE_REG_SKID_EN
  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    tick();
    in_data   = 16'h2222;
    tick();
    in_valid  = 1'b0;
    #1;
    total++; if (count !== 2'd2)      $display("FAIL bp_count got %0d want 2", count); else passed++;
    total++; if (in_ready !== 1'b0)   $display("FAIL bp_in_ready got %b want 0", in_ready); else passed++;
    total++; if (out_data !== 16'h1111) $display("FAIL bp_head got %h want 1111", out_data); else passed++;
    tick();
    total++; if (out_data !== 16'h1111 || out_valid !== 1'b1)
      $display("FAIL bp_hold got v=%b d=%h want v=1 d=1111", out_valid, out_data);
    else passed++;
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 16'h2222 || count !== 2'd1)
      $display("FAIL bp_second got d=%h count=%0d want 2222/1", out_data, count);
    else passed++;
    tick();
    total++; if (count !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL bp_empty got count=%0d v=%b want 0/0", count, out_valid);
    else passed++;
  endtask
`else
  task automatic test_replace();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    tick();
    #1;
    total++; if (count !== 2'd1 || out_data !== 16'h1111)
      $display("FAIL rep_first got count=%0d d=%h want 1/1111", count, out_data);
    else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL rep_stalled_ready got %b want 0", in_ready); else passed++;
    out_ready = 1'b1;
    in_data   = 16'h2222;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rep_comb_ready got %b want 1", in_ready); else passed++;
    tick();
    total++; if (count !== 2'd1 || out_data !== 16'h2222)
      $display("FAIL rep_replaced got count=%0d d=%h want 1/2222", count, out_data);
    else passed++;
    in_valid = 1'b0;
    tick();
    total++; if (count !== 2'd0) $display("FAIL rep_drain got %0d want 0", count); else passed++;
  endtask
`endif

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < MAX_CNT; i++) begin
      in_data = 16'hA000 + W'(i);
      tick();
    end
    total++; if (count !== 2'(MAX_CNT)) $display("FAIL flush_fill got %0d want %0d", count, MAX_CNT); else passed++;
    flush   = 1'b1;
    in_data = 16'hCCCC;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++; if (count !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL flush_empty got count=%0d v=%b want 0/0", count, out_valid);
    else passed++;
    total++; if (out_data !== RV) $display("FAIL flush_data got %h want %h", out_data, RV); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0 || out_data === 16'hCCCC)
        $display("FAIL flush_dropped[%0d] got v=%b d=%h want v=0 and no CCCC", i, out_valid, out_data);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < MAX_CNT; i++) begin
      in_data = 16'hB000 + W'(i);
      tick();
    end
    total++; if (count !== 2'(MAX_CNT)) $display("FAIL ares_fill got %0d want %0d", count, MAX_CNT); else passed++;
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    total++; if (count !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL ares_immediate got count=%0d v=%b want 0/0", count, out_valid);
    else passed++;
    total++; if (out_data !== RV) $display("FAIL ares_data got %h want %h", out_data, RV); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL ares_in_ready got %b want 1", in_ready); else passed++;
    @(negedge clk);
    total++; if (count !== 2'd0) $display("FAIL ares_held got %0d want 0", count); else passed++;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL ares_release_ready got %b want 1", in_ready); else passed++;
    tick();
    total++; if (count !== 2'd0) $display("FAIL ares_after got %0d want 0", count); else passed++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0) || (c % 512 < 64 && $urandom_range(0, 1) == 1);
      if (c % 512 >= 448) out_ready = 1'b0;
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = W'($urandom);
      #1;
      total++;
      if (count !== 2'(exp_q.size()) || count > 2'(MAX_CNT)) begin
        if (bad < 10) $display("FAIL rand_count[%0d] got %0d want %0d", c, count, exp_q.size());
        bad++;
      end else passed++;
      total++;
      if (out_valid !== (exp_q.size() > 0)) begin
        if (bad < 10) $display("FAIL rand_valid[%0d] got %b want %b", c, out_valid, exp_q.size() > 0);
        bad++;
      end else passed++;
      if (exp_q.size() > 0) begin
        total++;
        if (out_data !== exp_q[0]) begin
          if (bad < 10) $display("FAIL rand_data[%0d] got %h want %h", c, out_data, exp_q[0]);
          bad++;
        end else passed++;
      end
      total++;
      if (in_ready !== model_ready()) begin
        if (bad < 10) $display("FAIL rand_in_ready[%0d] got %b want %b", c, in_ready, model_ready());
        bad++;
      end else passed++;
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_streaming();
`ifdef PIPE_REG_SKID_EN
    test_backpressure();
`else
    test_replace();
`endif
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
